// File: rtl/uniq_pkg.sv
// Shared definitions for the uniq front-end scheduler.
//   DATA_W_DEF  default value width
//   NUM_LANES   number of output lanes
//   CNT_W_DEF   default duplicate counter width
//   lane_idx_t  lane index type
//   hist_ptr_w  history write-pointer width for a given depth
package uniq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [1:0] lane_idx_t;

  function automatic int unsigned hist_ptr_w(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uniq_hist.sv
// History of recently seen unique values.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   data_i         value offered this cycle
//   accept_i       value is transferred at the coming edge
//   clear_i        invalidate all entries and restart the write pointer
//   hit_o          data_i matches a valid entry (forced low while clearing)
module uniq_hist
  import uniq_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              accept_i,
  input  logic              clear_i,
  output logic              hit_o
);

  localparam int unsigned PtrW = hist_ptr_w(HIST_DEPTH);

  logic [DATA_W-1:0]     entry_q [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       wr_idx;
  logic [HIST_DEPTH-1:0] match;
  logic                  write;

  always_comb begin
    match = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      match[i] = valid_q[i] && (entry_q[i] == data_i);
    end
  end

  // A clear in the same cycle empties the history first, so nothing can hit.
  assign hit_o = (|match) && !clear_i;
  assign write = accept_i && !hit_o;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx   = wr_ptr_q;
    if (clear_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      wr_idx   = '0;
    end
    if (write) begin
      valid_d[wr_idx] = 1'b1;
      wr_ptr_d        = wr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      if (write) entry_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/uniq_dispatch.sv
// Front-end scheduler: drops values still in the recent-unique history and
// dispatches survivors round-robin over four lanes, skipping stalled lanes.
//   clk_in, rst_n_in                     clock, asynchronous active-low reset
//   data_in/_valid/_ready                input stream handshake
//   clear_in                             invalidate the whole history
//   data_out_k/_valid_k/_ready_k (k=1..4) lane outputs and consumer ready
//   dup_cnt                              saturating count of dropped duplicates
module uniq_dispatch
  import uniq_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic              clear_in,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [DATA_W-1:0] data_out_4,
  output logic              data_out_valid_1,
  output logic              data_out_valid_2,
  output logic              data_out_valid_3,
  output logic              data_out_valid_4,
  input  logic              data_out_ready_1,
  input  logic              data_out_ready_2,
  input  logic              data_out_ready_3,
  input  logic              data_out_ready_4,
  output logic [CNT_W-1:0]  dup_cnt
);

  logic                 pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]    pend_data_q, pend_data_d;
  logic [DATA_W-1:0]    lane_data_q [NUM_LANES];
  logic [DATA_W-1:0]    lane_data_d [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic [NUM_LANES-1:0] lane_ready, lane_free;
  lane_idx_t            rr_q, rr_d;
  lane_idx_t            sel, cand;
  logic                 found;
  logic                 dispatch, accept, hit;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign lane_ready = {data_out_ready_4, data_out_ready_3, data_out_ready_2, data_out_ready_1};
  assign lane_free  = ~lane_valid_q | lane_ready;

  // First free lane at or after rr.
  always_comb begin
    sel   = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = rr_q + lane_idx_t'(i);
      if (!found && lane_free[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign dispatch      = pend_valid_q && found;
  assign data_in_ready = !pend_valid_q || dispatch;
  assign accept        = data_in_valid && data_in_ready;

  uniq_hist #(
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .data_i   (data_in),
    .accept_i (accept),
    .clear_i  (clear_in),
    .hit_o    (hit)
  );

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    lane_valid_d = lane_valid_q;
    lane_data_d  = lane_data_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;

    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_ready[k]) lane_valid_d[k] = 1'b0;
    end
    if (dispatch) begin
      lane_valid_d[sel] = 1'b1;
      lane_data_d[sel]  = pend_data_q;
      rr_d              = sel + 1'b1;
      pend_valid_d      = 1'b0;
    end

    // A new unique value replaces whatever just left pending.
    if (accept && !hit) begin
      pend_valid_d = 1'b1;
      pend_data_d  = data_in;
    end
    if (accept && hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      lane_valid_q <= '0;
      for (int k = 0; k < NUM_LANES; k++) lane_data_q[k] <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      lane_valid_q <= lane_valid_d;
      lane_data_q  <= lane_data_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data_out_1       = lane_data_q[0];
  assign data_out_2       = lane_data_q[1];
  assign data_out_3       = lane_data_q[2];
  assign data_out_4       = lane_data_q[3];
  assign data_out_valid_1 = lane_valid_q[0];
  assign data_out_valid_2 = lane_valid_q[1];
  assign data_out_valid_3 = lane_valid_q[2];
  assign data_out_valid_4 = lane_valid_q[3];
  assign dup_cnt          = cnt_q;

endmodule

// File: tb/tb_uniq_dispatch.sv
// Scoreboard bench for uniq_dispatch: a reference model evaluates each coming
// edge from the settled inputs and queues the expected lane/counter state; a
// monitor pops it after the edge and compares against the DUT.
module tb_uniq_dispatch;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       clear_in;
  logic [3:0] rdy;
  logic [7:0] d1, d2, d3, d4;
  logic       v1, v2, v3, v4;
  logic [15:0] dup;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uniq_dispatch dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_ready    (data_in_ready),
    .clear_in         (clear_in),
    .data_out_1       (d1),
    .data_out_2       (d2),
    .data_out_3       (d3),
    .data_out_4       (d4),
    .data_out_valid_1 (v1),
    .data_out_valid_2 (v2),
    .data_out_valid_3 (v3),
    .data_out_valid_4 (v4),
    .data_out_ready_1 (rdy[0]),
    .data_out_ready_2 (rdy[1]),
    .data_out_ready_3 (rdy[2]),
    .data_out_ready_4 (rdy[3]),
    .dup_cnt          (dup)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic [15:0] dup;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] hist[$];    // recent unique values, oldest first
  logic [7:0] pend_q[$];  // accepted unique values not yet on a lane
  logic [3:0] mv;
  logic [7:0] md[4];
  int         m_rr;
  int         m_dup;

  initial begin : model
    logic [3:0] free;
    logic       exp_rdy, load, hitv;
    int         sel;
    rec_t       r;
    mv = '0; m_rr = 0; m_dup = 0;
    for (int k = 0; k < 4; k++) md[k] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mv = '0; m_rr = 0; m_dup = 0;
        for (int k = 0; k < 4; k++) md[k] = '0;
        hist.delete(); pend_q.delete(); exp_q.delete();
      end else begin
        free    = ~mv | rdy;
        exp_rdy = (pend_q.size() == 0) || (free != 4'b0);
        chk("data_in_ready", int'(data_in_ready), int'(exp_rdy));
        load = (pend_q.size() != 0) && (free != 4'b0);
        sel  = -1;
        if (load) begin
          for (int i = 0; i < 4; i++) begin
            if (sel < 0 && free[(m_rr + i) % 4]) sel = (m_rr + i) % 4;
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (k == sel) begin
            mv[k] = 1'b1;
            md[k] = pend_q.pop_front();
            m_rr  = (k + 1) % 4;
          end else if (rdy[k]) begin
            mv[k] = 1'b0;
          end
        end
        if (clear_in) hist.delete();
        if (data_in_valid && exp_rdy) begin
          hitv = 1'b0;
          foreach (hist[i]) if (hist[i] == data_in) hitv = 1'b1;
          if (hitv) begin
            if (m_dup != 16'hFFFF) m_dup++;
          end else begin
            hist.push_back(data_in);
            if (hist.size() > Depth) void'(hist.pop_front());
            pend_q.push_back(data_in);
          end
        end
        r.v   = mv;
        r.d   = {md[3], md[2], md[1], md[0]};
        r.dup = 16'(m_dup);
        exp_q.push_back(r);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    rec_t        r;
    logic [3:0]  dv;
    logic [31:0] dd;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        r  = exp_q.pop_front();
        dv = {v4, v3, v2, v1};
        dd = {d4, d3, d2, d1};
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("lane%0d_valid", k + 1), int'(dv[k]), int'(r.v[k]));
          if (r.v[k]) chk($sformatf("lane%0d_data", k + 1), int'(dd[8*k +: 8]),
                          int'(r.d[8*k +: 8]));
        end
        chk("dup_cnt", int'(dup), int'(r.dup));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] v);
    logic r;
    int   budget;
    budget        = 50;
    data_in       = v;
    data_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = data_in_ready;
      tick();
      if (r) break;
      budget--;
      if (budget == 0) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    data_in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] seq1[11];
    rst_n = 1'b0; data_in = '0; data_in_valid = 1'b0; clear_in = 1'b0; rdy = 4'hF;
    #12;
    chk("rst_in_ready", int'(data_in_ready), 1);
    chk("rst_valids", int'({v4, v3, v2, v1}), 0);
    chk("rst_data", int'({d4, d3, d2, d1}), 0);
    chk("rst_dup", int'(dup), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: dedup and round-robin
    seq1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h05, 8'h06, 8'h06, 8'h04, 8'h08, 8'h09};
    foreach (seq1[i]) send(seq1[i]);
    repeat (3) tick();
    chk("t1_dup", int'(dup), 3);

    // 2: lane 2 stalled
    rdy[1] = 1'b0;
    for (int v = 8'h0A; v <= 8'h0F; v++) send(8'(v));
    repeat (3) tick();
    chk("t2_lane2_hold", int'(d2), 8'h0B);
    rdy[1] = 1'b1;
    repeat (2) tick();

    // 3: all lanes stalled, pending backs up
    rdy = 4'h0;
    for (int v = 8'h11; v <= 8'h15; v++) send(8'(v));
    repeat (2) tick();
    chk("t3_in_ready_low", int'(data_in_ready), 0);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    chk("t3_lane1_data", int'(d1), 8'h15);
    chk("t3_in_ready_back", int'(data_in_ready), 1);
    rdy = 4'hF;
    repeat (2) tick();

    // 4: history wrap
    for (int v = 8'h20; v <= 8'h28; v++) send(8'(v));
    send(8'h20);
    repeat (3) tick();
    chk("t4_dup", int'(dup), 3);

    // 5: clear
    send(8'h30);
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    send(8'h30);
    clear_in = 1'b1; send(8'h31); clear_in = 1'b0;
    send(8'h31);
    repeat (3) tick();
    chk("t5_dup", int'(dup), 4);

    // 6: asynchronous reset with lanes full and pending occupied
    rdy = 4'h0;
    for (int v = 8'h50; v <= 8'h54; v++) send(8'(v));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valids", int'({v4, v3, v2, v1}), 0);
    chk("t6_dup", int'(dup), 0);
    chk("t6_in_ready", int'(data_in_ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    rdy   = 4'hF;
    send(8'h77);
    tick();
    chk("t6_lane1_valid", int'(v1), 1);
    chk("t6_lane1_data", int'(d1), 8'h77);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      rdy           = 4'($urandom_range(0, 15));
      data_in_valid = ($urandom_range(0, 9) < 7);
      data_in       = 8'($urandom_range(0, 15) + 8'h40);
      clear_in      = ($urandom_range(0, 99) < 3);
      tick();
    end
    data_in_valid = 1'b0;
    clear_in      = 1'b0;
    rdy           = 4'hF;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
